// File: rtl/if_feed_pkg.sv
// Shared definitions for the IF feed path: FSM state encoding, tag bit
// positions within a FIFO word, and the tag encoding seen by the IF read path.
package if_feed_pkg;

    // Feeder FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        DONE = 2'd2
    } feed_state_t;

    // Two-bit tag carried above the data bits: {start-of-row, end-of-row}
    typedef enum logic [1:0] {
        TAG_MID  = 2'b00,
        TAG_EOR  = 2'b01,
        TAG_SOR  = 2'b10,
        TAG_SOLO = 2'b11
    } if_tag_t;

    // Bit position of the start-of-row tag in a word with w data bits
    function automatic int unsigned sor_pos(input int unsigned w);
        return w + 1;
    endfunction

    // Bit position of the end-of-row tag in a word with w data bits
    function automatic int unsigned eor_pos(input int unsigned w);
        return w;
    endfunction

    // Build a tag from its two flags
    function automatic if_tag_t make_tag(input logic sor, input logic eor);
        return if_tag_t'({sor, eor});
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Up-counter that wraps to zero when enabled while sitting on its limit.
// The limit is the last value reached (inclusive); at_last flags it.
module wrap_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             at_last
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign at_last = (count_q == limit);
    assign count   = count_q;

    // Next count: clear wins, otherwise step and wrap at the limit
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            if (at_last) begin
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/if_row_tagger.sv
// Feeds raw IF values into the IF FIFO, tagging the first and last value of
// each row. The FIFO full flag backpressures the source combinationally and
// done pulses once the last word of a programmed frame has been written.
module if_row_tagger
    import if_feed_pkg::*;
#(
    parameter int unsigned IF_SCRATCH_WIDTH = 8,
    parameter int unsigned IF_ADDR_LEN      = 8,
    parameter int unsigned ROW_CNT_LEN      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [IF_ADDR_LEN-1:0]      row_len,
    input  logic [ROW_CNT_LEN-1:0]      num_rows,
    input  logic                        src_valid,
    input  logic [IF_SCRATCH_WIDTH-1:0] src_data,
    output logic                        src_ready,
    input  logic                        IF_full,
    output logic                        IF_wen,
    output logic [IF_SCRATCH_WIDTH+1:0] IF_din,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned W       = IF_SCRATCH_WIDTH;
    localparam int unsigned SOR_BIT = sor_pos(IF_SCRATCH_WIDTH);
    localparam int unsigned EOR_BIT = eor_pos(IF_SCRATCH_WIDTH);

    feed_state_t state_q, state_d;
    logic [IF_ADDR_LEN-1:0] row_len_q, row_len_d;
    logic [ROW_CNT_LEN-1:0] num_rows_q, num_rows_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic [IF_ADDR_LEN-1:0] col_cnt;
    logic [IF_ADDR_LEN-1:0] col_limit;
    logic [ROW_CNT_LEN-1:0] row_cnt;
    logic [ROW_CNT_LEN-1:0] row_limit;
    logic col_last;
    logic row_last;
    logic col_first;
    logic start_ok;
    logic zero_frame;
    logic xfer;
    logic [W+1:0] din_d;

    assign start_ok   = start && (state_q == IDLE);
    assign zero_frame = (row_len == '0) || (num_rows == '0);
    assign col_limit  = row_len_q - 1'b1;
    assign row_limit  = num_rows_q - 1'b1;
    assign col_first  = (col_cnt == '0);

    assign src_ready = (state_q == FEED) && !IF_full;
    assign xfer      = src_ready && src_valid;
    assign IF_wen    = xfer;
    assign IF_din    = din_d;
    assign busy      = busy_q;
    assign done      = done_q;

    // Tagged FIFO word; held at zero whenever no transfer takes place
    always_comb begin
        din_d = '0;
        if (xfer) begin
            din_d[W-1:0]   = src_data;
            din_d[SOR_BIT] = col_first;
            din_d[EOR_BIT] = col_last;
        end
    end

    wrap_counter #(
        .WIDTH (IF_ADDR_LEN)
    ) u_col_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_ok),
        .en      (xfer),
        .limit   (col_limit),
        .count   (col_cnt),
        .at_last (col_last)
    );

    wrap_counter #(
        .WIDTH (ROW_CNT_LEN)
    ) u_row_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_ok),
        .en      (xfer && col_last),
        .limit   (row_limit),
        .count   (row_cnt),
        .at_last (row_last)
    );

    // Next state, config latch and registered status flags
    always_comb begin
        state_d    = state_q;
        row_len_d  = row_len_q;
        num_rows_d = num_rows_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    row_len_d  = row_len;
                    num_rows_d = num_rows;
                    state_d    = zero_frame ? DONE : FEED;
                end
            end
            FEED: begin
                if (xfer && col_last && row_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // FSM and config registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            row_len_q  <= '0;
            num_rows_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_len_q  <= row_len_d;
            num_rows_q <= num_rows_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // While feeding, both counters stay within the latched frame geometry
    a_cnt_in_range: assert property (@(posedge clk) disable iff (rst)
        (state_q == FEED) |-> ((col_cnt <= col_limit) && (row_cnt <= row_limit)));

endmodule

// File: tb/tb_if_row_tagger.sv
module tb_if_row_tagger;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] row_len;
    logic [7:0] num_rows;
    logic       src_valid;
    logic [7:0] src_data;
    logic       src_ready;
    logic       IF_full;
    logic       IF_wen;
    logic [9:0] IF_din;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    if_row_tagger #(
        .IF_SCRATCH_WIDTH (8),
        .IF_ADDR_LEN      (8),
        .ROW_CNT_LEN      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .row_len   (row_len),
        .num_rows  (num_rows),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .IF_full   (IF_full),
        .IF_wen    (IF_wen),
        .IF_din    (IF_din),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       start;
        logic [7:0] rl;
        logic [7:0] nr;
        logic       v;
        logic [7:0] d;
        logic       full;
        logic       e_rdy;
        logic       e_wen;
        logic [9:0] e_din;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic s, input logic [7:0] rl, input logic [7:0] nr,
                       input logic v, input logic [7:0] d, input logic f,
                       input logic er, input logic ew, input logic [9:0] ed,
                       input logic eb, input logic edn);
        vec_t x;
        x.rst = r; x.start = s; x.rl = rl; x.nr = nr; x.v = v; x.d = d; x.full = f;
        x.e_rdy = er; x.e_wen = ew; x.e_din = ed; x.e_busy = eb; x.e_done = edn;
        vecs.push_back(x);
    endtask

    // Shorthands: idle cycle, accepted-start cycle, transfer, stall, done cycle
    task automatic v_idle();            add(0, 0, 8'd0, 8'd0, 0, 8'h00, 0, 0, 0, 10'h000, 0, 0); endtask
    task automatic v_start(input logic [7:0] rl, input logic [7:0] nr);
                                        add(0, 1, rl, nr, 1, 8'h55, 0, 0, 0, 10'h000, 0, 0); endtask
    task automatic v_wr(input logic [7:0] d, input logic [9:0] din);
                                        add(0, 0, 8'd0, 8'd0, 1, d, 0, 1, 1, din, 1, 0); endtask
    task automatic v_done();            add(0, 0, 8'd0, 8'd0, 1, 8'h77, 0, 0, 0, 10'h000, 1, 1); endtask

    initial begin
        bit seen;

        rst = 1'b1; start = 1'b0; row_len = '0; num_rows = '0;
        src_valid = 1'b0; src_data = '0; IF_full = 1'b0;

        // reset state
        add(1, 0, 8'd0, 8'd0, 1, 8'hAA, 0, 0, 0, 10'h000, 0, 0);
        v_idle();

        // 3x2 frame, valid held high: tags 10,00,01,10,00,01
        v_start(8'd3, 8'd2);
        v_wr(8'd1, 10'h201); v_wr(8'd2, 10'h002); v_wr(8'd3, 10'h103);
        v_wr(8'd4, 10'h204); v_wr(8'd5, 10'h005); v_wr(8'd6, 10'h106);
        // start during done is ignored
        add(0, 1, 8'd1, 8'd1, 1, 8'h77, 0, 0, 0, 10'h000, 1, 1);
        v_idle();

        // 3x2 frame with 4-cycle full stall after word 2; a restart mid-stall is ignored
        v_start(8'd3, 8'd2);
        v_wr(8'd1, 10'h201); v_wr(8'd2, 10'h002);
        add(0, 0, 8'd0, 8'd0, 1, 8'd3, 1, 0, 0, 10'h000, 1, 0);
        add(0, 1, 8'd1, 8'd1, 1, 8'd3, 1, 0, 0, 10'h000, 1, 0);
        add(0, 0, 8'd0, 8'd0, 1, 8'd3, 1, 0, 0, 10'h000, 1, 0);
        add(0, 0, 8'd0, 8'd0, 1, 8'd3, 1, 0, 0, 10'h000, 1, 0);
        v_wr(8'd3, 10'h103); v_wr(8'd4, 10'h204); v_wr(8'd5, 10'h005); v_wr(8'd6, 10'h106);
        v_done();
        v_idle();

        // row_len=1: every word tagged 11; an idle-source cycle in between
        v_start(8'd1, 8'd3);
        v_wr(8'h0A, 10'h30A);
        add(0, 0, 8'd0, 8'd0, 0, 8'h0B, 0, 1, 0, 10'h000, 1, 0);
        v_wr(8'h0B, 10'h30B); v_wr(8'h0C, 10'h30C);
        v_done();
        v_idle();

        // zero-size frames: done in the very next cycle, no writes
        v_start(8'd0, 8'd5);
        v_done();
        v_idle();
        v_start(8'd4, 8'd0);
        v_done();
        v_idle();

        // reset after word 4 of a 3x3 frame, then a clean 2x2 frame
        v_start(8'd3, 8'd3);
        v_wr(8'd1, 10'h201); v_wr(8'd2, 10'h002); v_wr(8'd3, 10'h103); v_wr(8'd4, 10'h204);
        add(1, 0, 8'd0, 8'd0, 1, 8'd5, 0, 0, 0, 10'h000, 0, 0);
        add(0, 0, 8'd0, 8'd0, 1, 8'd5, 0, 0, 0, 10'h000, 0, 0);
        v_start(8'd2, 8'd2);
        v_wr(8'd1, 10'h201); v_wr(8'd2, 10'h102); v_wr(8'd3, 10'h203); v_wr(8'd4, 10'h104);
        v_done();
        v_idle();

        // apply the table: drive just after the rising edge, compare on the falling edge
        @(posedge clk);
        foreach (vecs[i]) begin
            #1;
            rst = vecs[i].rst; start = vecs[i].start; row_len = vecs[i].rl; num_rows = vecs[i].nr;
            src_valid = vecs[i].v; src_data = vecs[i].d; IF_full = vecs[i].full;
            @(negedge clk);
            chk($sformatf("v%0d_ready", i), 32'(src_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_wen",   i), 32'(IF_wen),    32'(vecs[i].e_wen));
            chk($sformatf("v%0d_din",   i), 32'(IF_din),    32'(vecs[i].e_din));
            chk($sformatf("v%0d_busy",  i), 32'(busy),      32'(vecs[i].e_busy));
            chk($sformatf("v%0d_done",  i), 32'(done),      32'(vecs[i].e_done));
            @(posedge clk);
        end

        // config changes and restart mid-frame take no effect on a 2x1 frame
        #1; rst = 1'b0; start = 1'b1; row_len = 8'd2; num_rows = 8'd1; src_valid = 1'b0; IF_full = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; row_len = 8'd5; num_rows = 8'd7; src_valid = 1'b1; src_data = 8'h11;
        @(negedge clk);
        chk("ms_w1_wen", 32'(IF_wen), 32'd1);
        chk("ms_w1_din", 32'(IF_din), 32'h211);
        @(posedge clk); #1;
        start = 1'b0; src_data = 8'h22;
        @(negedge clk);
        chk("ms_w2_din", 32'(IF_din), 32'h122);
        @(posedge clk); #1;
        src_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("ms_done_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ms_idle_busy", 32'(busy), 32'd0);
        chk("ms_idle_done", 32'(done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_row_tagger.md
# if_row_tagger

Upstream feeder for the input-feature (IF) FIFO of the convolution accelerator. Accepts a raw stream of IF values over a valid/ready handshake, counts them into rows of a programmed length, and writes each value into the IF FIFO with a start-of-row and end-of-row tag appended. It applies the FIFO's full flag as backpressure to the source and reports completion of a programmed frame.

## Interface
- IF_SCRATCH_WIDTH, 8, data width of one IF value; the FIFO word is IF_SCRATCH_WIDTH+2.
- IF_ADDR_LEN, 8, width of the row-length and column counter.
- ROW_CNT_LEN, 8, width of the row-count and row counter.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; latches the config and begins a frame.
- row_len  in  IF_ADDR_LEN  values per row; sampled only on an accepted start.
- num_rows  in  ROW_CNT_LEN  rows per frame; sampled only on an accepted start.
- src_valid  in  1  source holds a valid value.
- src_data  in  IF_SCRATCH_WIDTH  IF value.
- src_ready  out  1  block accepts a value this cycle.
- IF_full  in  1  full flag of the IF FIFO.
- IF_wen  out  1  write enable to the IF FIFO.
- IF_din  out  IF_SCRATCH_WIDTH+2  tagged word: bit W+1 = start-of-row, bit W = end-of-row, bits W-1:0 = data (W = IF_SCRATCH_WIDTH).
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the last word of a frame is written.

## Operation
- FSM states: IDLE, FEED, DONE.
- IDLE:
  - start latches row_len and num_rows, clears the column and row counters, and moves to FEED.
  - If the latched row_len==0 or num_rows==0, go to DONE instead; no words are written.
- FEED:
  - src_ready = ~IF_full.
  - A transfer occurs when src_valid & src_ready. On a transfer, IF_wen=1 and IF_din={col==0, col==row_len-1, src_data}.
  - On a transfer, col increments. When col==row_len-1, col wraps to 0 and row increments.
  - A transfer with col==row_len-1 and row==num_rows-1 is the last word of the frame; the FSM moves to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in FEED and DONE.
- start is ignored while in FEED or DONE.
- row_len==1: every word carries both tags (11).
- The column and row counters never exceed the latched limits. No transfer occurs outside FEED.
- Reset (any cycle, including mid-frame): FSM returns to IDLE, counters clear, and every output goes to 0. Words already written to the FIFO are not recalled.

## Timing
- Reset values: src_ready=0, IF_wen=0, IF_din=0, busy=0, done=0.
- IF_wen, IF_din and src_ready are combinational from src_valid, src_data, IF_full and the registered state and counters. Latency from src to FIFO is zero cycles.
- IF_full is honoured in the same cycle: when IF_full=1, IF_wen=0 and src_ready=0. IF_wen is never asserted while IF_full=1.
- Cycle-level timing of a frame:
  - start seen at edge N; FEED in cycle N+1.
  - The last transfer happens at edge M; done=1 in cycle M+1; IDLE in cycle M+2.
  - For a zero-size frame: start at edge N, done in cycle N+1.
- The source may hold src_valid high across stalls; data is consumed only on a transfer.
- A start pulse that arrives during the done cycle is ignored.

## Structure
- Shared package if_feed_pkg holds:
  - the state typedef (IDLE/FEED/DONE);
  - the tag bit-position constants (SOR = W+1, EOR = W) as functions of IF_SCRATCH_WIDTH;
  - the tag encoding shared with the IF read path.
- One sub-module, wrap_counter: parameterized width, with clear, enable, limit input, at_last output, and wrap on enable at the limit. It is instantiated twice, for the column counter and the row counter.

## Test plan
- row_len=3, num_rows=2, src_valid held high, data 1..6, IF_full=0: six consecutive writes with tags 10,00,01,10,00,01; done pulses 1 cycle after word 6.
- Same frame with IF_full=1 for 4 cycles after word 2: src_ready=0 and IF_wen=0 during the stall; data order is preserved and the tags are unchanged.
- row_len=1, num_rows=3: three words, each tagged 11; done follows the third word.
- row_len=0 (or num_rows=0): start produces no IF_wen, src_ready stays 0, and done pulses in cycle N+1.
- rst asserted after word 4 of a 3x3 frame: all outputs go to 0 immediately. A new start with 2x2 then produces tags 10,01,10,01, so no stale count carries over.
- start re-pulsed mid-frame and during done: ignored, and row_len and num_rows changes take no effect until the next accepted start.
